adc_frame_serializer: RTL and testbench

Transmit-side counterpart of the ADC LVDS capture path: serializes 16-bit samples into the same two-lane, 8-bit-per-lane, frame-clocked bitstream that the ADC drives into the receiver. Used as an on-chip loopback/emulation source so that deserializer alignment, bitslip and the FIFO/Ethernet chain can be exercised without the physical ADC. Samples come from an external valid/ready stream or an internal pattern generator. Output is SDR, one bit per lane per `clk`; any DDR/OSERDES stage sits outside this block.

---
 rtl/adc_frame_serializer.sv | 135 +++++++++++++
 tb/tb_adc_frame_serializer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_serializer.sv
// Two-lane SDR serializer emulating the ADC LVDS output: 16-bit words, 8 bits per lane,
// framed by fclk. Word source is an external valid/ready stream or an internal pattern.
module adc_frame_serializer #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [SAMPLE_W-1:0] fixed_pattern,
    input  logic [2:0]          frame_shift,
    input  logic [SAMPLE_W-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                d0,
    output logic                d1,
    output logic                fclk,
    output logic                frame_start,
    output logic [CNT_W-1:0]    underrun_cnt
);

    localparam int unsigned PH_W = 3;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(7);
    localparam logic [1:0] MODE_EXT   = 2'd0;
    localparam logic [1:0] MODE_RAMP  = 2'd1;
    localparam logic [1:0] MODE_FIXED = 2'd2;
    localparam logic [SAMPLE_W-1:0] ALT_A = SAMPLE_W'(16'hAAAA);
    localparam logic [SAMPLE_W-1:0] ALT_B = SAMPLE_W'(16'h5555);

    // ph_q is the phase of the bit pair currently driven on the lanes; it rests at the
    // last phase in reset so the first edge after reset starts frame 0 at phase 0.
    logic [PH_W-1:0]     ph_q, ph_d;
    logic                first_q, first_d;
    logic [SAMPLE_W-1:0] shreg_q, shreg_d;
    logic [PH_W-1:0]     shift_q, shift_d;
    logic [SAMPLE_W-1:0] ramp_q, ramp_d;
    logic                alt_q, alt_d;
    logic [CNT_W-1:0]    underrun_cnt_q, underrun_cnt_d;
    logic                d0_q, d0_d;
    logic                d1_q, d1_d;
    logic                fclk_q, fclk_d;
    logic                frame_start_q, frame_start_d;
    logic                s_ready_q, s_ready_d;
    logic [SAMPLE_W-1:0] word;
    logic [PH_W-1:0]     fclk_pos;

    // Next-state: word selection at the frame boundary, lane shifting otherwise
    always_comb begin
        ph_d           = ph_q + PH_W'(1);
        first_d        = 1'b0;
        shift_d        = shift_q;
        ramp_d         = ramp_q;
        alt_d          = alt_q;
        underrun_cnt_d = underrun_cnt_q;
        word           = '0;
        shreg_d        = {shreg_q[SAMPLE_W-3:0], 2'b00};

        if (ph_q == PH_LAST) begin
            // The boundary right out of reset is frame 0: zero word, zero shift.
            if (!first_q) begin
                shift_d = frame_shift;
                if (en) begin
                    case (mode)
                        MODE_EXT: begin
                            if (s_ready_q && s_valid) begin
                                word = s_data;
                            end else if (underrun_cnt_q != {CNT_W{1'b1}}) begin
                                underrun_cnt_d = underrun_cnt_q + CNT_W'(1);
                            end
                        end
                        MODE_RAMP: begin
                            word   = ramp_q;
                            ramp_d = ramp_q + SAMPLE_W'(1);
                        end
                        MODE_FIXED: begin
                            word = fixed_pattern;
                        end
                        default: begin
                            word  = alt_q ? ALT_B : ALT_A;
                            alt_d = ~alt_q;
                        end
                    endcase
                end
            end
            shreg_d = word;
        end

        d1_d          = shreg_d[SAMPLE_W-1];
        d0_d          = shreg_d[SAMPLE_W-2];
        fclk_pos      = ph_d + shift_d;
        fclk_d        = ~fclk_pos[PH_W-1];
        frame_start_d = (ph_d == '0);
        // Offer a slot only in the last phase so one sample is taken per frame
        s_ready_d     = (ph_d == PH_LAST) && en && (mode == MODE_EXT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q           <= PH_LAST;
            first_q        <= 1'b1;
            shreg_q        <= '0;
            shift_q        <= '0;
            ramp_q         <= '0;
            alt_q          <= 1'b0;
            underrun_cnt_q <= '0;
            d0_q           <= 1'b0;
            d1_q           <= 1'b0;
            fclk_q         <= 1'b0;
            frame_start_q  <= 1'b0;
            s_ready_q      <= 1'b0;
        end else begin
            ph_q           <= ph_d;
            first_q        <= first_d;
            shreg_q        <= shreg_d;
            shift_q        <= shift_d;
            ramp_q         <= ramp_d;
            alt_q          <= alt_d;
            underrun_cnt_q <= underrun_cnt_d;
            d0_q           <= d0_d;
            d1_q           <= d1_d;
            fclk_q         <= fclk_d;
            frame_start_q  <= frame_start_d;
            s_ready_q      <= s_ready_d;
        end
    end

    assign d0           = d0_q;
    assign d1           = d1_q;
    assign fclk         = fclk_q;
    assign frame_start  = frame_start_q;
    assign s_ready      = s_ready_q;
    assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_adc_frame_serializer.sv
// Frame-level scoreboard bench for adc_frame_serializer: a driver issues one configuration
// per frame and queues the expected frame; a negedge monitor decodes lanes and compares.
module tb_adc_frame_serializer;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [15:0] fixed_pattern;
    logic [2:0]  frame_shift;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        d0;
    logic        d1;
    logic        fclk;
    logic        frame_start;
    logic [15:0] underrun_cnt;

    adc_frame_serializer #(.SAMPLE_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .fixed_pattern(fixed_pattern),
        .frame_shift(frame_shift), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .d0(d0), .d1(d1), .fclk(fclk), .frame_start(frame_start), .underrun_cnt(underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        int          shift;
        int          under;
        bit          rdy;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state, kept as plain integers
    int m_ramp;
    int m_under;
    bit m_second;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] fclk_expected(input int s);
        logic [7:0] f;
        for (int p = 0; p < 8; p++) f[p] = (((p + s) % 8) < 4);
        return f;
    endfunction

    // One frame boundary of the reference: what the next frame must carry
    task automatic model_step(input bit c_en, input int c_mode, input logic [15:0] c_pat,
                              input int c_shift, input bit c_valid, input logic [15:0] c_data);
        exp_t e;
        e.word  = 16'h0000;
        e.shift = c_shift;
        e.rdy   = 1'b0;
        if (c_en) begin
            if (c_mode == 0) begin
                e.rdy = 1'b1;
                if (c_valid) e.word = c_data;
                else if (m_under < 65535) m_under = m_under + 1;
            end else if (c_mode == 1) begin
                e.word = 16'(m_ramp);
                m_ramp = (m_ramp + 1) % 65536;
            end else if (c_mode == 2) begin
                e.word = c_pat;
            end else begin
                e.word   = m_second ? 16'h5555 : 16'hAAAA;
                m_second = !m_second;
            end
        end
        e.under = m_under;
        exp_q.push_back(e);
    endtask

    // Monitor
    bit         mon_active = 1'b0;
    int         mcyc;
    logic [7:0] prev_rdy;

    always @(negedge clk) begin : monitor
        int          ph;
        exp_t        e;
        logic [15:0] m_word;
        logic [7:0]  fclk_m, fs_m, rdy_m;
        logic [15:0] under_p0;
        if (mon_active) begin
            ph = mcyc % 8;
            if (ph == 0) begin
                m_word   = '0;
                fclk_m   = '0;
                fs_m     = '0;
                rdy_m    = '0;
                under_p0 = underrun_cnt;
            end
            m_word[15 - 2*ph] = d1;
            m_word[14 - 2*ph] = d0;
            fclk_m[ph] = fclk;
            fs_m[ph]   = frame_start;
            rdy_m[ph]  = s_ready;
            if (ph == 7) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL scoreboard: frame 0x%0h decoded with nothing expected", m_word);
                end else begin
                    e = exp_q.pop_front();
                    check("word", 32'(m_word), 32'(e.word));
                    check("fclk", 32'(fclk_m), 32'(fclk_expected(e.shift)));
                    check("frame_start", 32'(fs_m), 32'h01);
                    check("underrun_cnt", 32'(under_p0), 32'(e.under));
                    check("s_ready", 32'(prev_rdy), e.rdy ? 32'h80 : 32'h00);
                end
                prev_rdy = rdy_m;
            end
            mcyc++;
        end
    end

    // Called #1 after a posedge; returns #1 after the edge that starts frame 0
    task automatic do_reset(input int n);
        exp_t e;
        rst = 1'b1;
        mon_active = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            check("reset_outputs",
                  32'({d0, d1, fclk, frame_start, s_ready, underrun_cnt}), 32'h0);
        end
        rst = 1'b0;
        exp_q.delete();
        m_ramp   = 0;
        m_under  = 0;
        m_second = 1'b0;
        @(posedge clk); #1;
        mcyc       = 0;
        prev_rdy   = '0;
        e.word = 16'h0000; e.shift = 0; e.under = 0; e.rdy = 1'b0;
        exp_q.push_back(e);
        mon_active = 1'b1;
    endtask

    // Called at phase 0 (+#1); scrambles inputs early in the frame, applies the real
    // configuration at phase 4, and returns at phase 0 of the following frame.
    task automatic run_frame(input bit c_en, input int c_mode, input logic [15:0] c_pat,
                             input int c_shift, input bit c_valid, input logic [15:0] c_data,
                             input bit frc_ramp, input bit frc_under);
        @(posedge clk); #1;
        en            = 1'($urandom);
        mode          = 2'($urandom);
        fixed_pattern = 16'($urandom);
        frame_shift   = 3'($urandom);
        s_valid       = 1'($urandom);
        s_data        = 16'($urandom);
        if (frc_ramp) begin
            force dut.ramp_q = 16'hFFFF;
            m_ramp = 65535;
        end
        if (frc_under) begin
            force dut.underrun_cnt_q = 16'hFFFF;
            m_under = 65535;
        end
        @(posedge clk); #1;
        if (frc_ramp) release dut.ramp_q;
        if (frc_under) release dut.underrun_cnt_q;
        repeat (2) @(posedge clk);
        #1;
        en            = c_en;
        mode          = 2'(c_mode);
        fixed_pattern = c_pat;
        frame_shift   = 3'(c_shift);
        s_valid       = c_valid;
        s_data        = c_data;
        model_step(c_en, c_mode, c_pat, c_shift, c_valid, c_data);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        rst = 1'b1; en = 1'b0; mode = 2'd0; fixed_pattern = '0; frame_shift = '0;
        s_data = '0; s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        en = 1'b1; mode = 2'd1;
        do_reset(5);

        // Ramp from reset, then forced wrap
        repeat (3) run_frame(1, 1, 16'h0, 0, 0, 16'h0, 0, 0);
        run_frame(1, 1, 16'h0, 0, 0, 16'h0, 1, 0);
        run_frame(1, 1, 16'h0, 0, 0, 16'h0, 0, 0);

        // External stream and underrun, including saturation
        repeat (2) run_frame(1, 0, 16'h0, 0, 1, 16'hA5C3, 0, 0);
        repeat (3) run_frame(1, 0, 16'h0, 0, 0, 16'h0, 0, 0);
        run_frame(1, 0, 16'h0, 0, 0, 16'h0, 0, 1);
        run_frame(1, 0, 16'h0, 0, 0, 16'h0, 0, 0);

        // Reset in the middle of a frame
        repeat (3) @(posedge clk);
        #1;
        do_reset(5);

        // Frame shift with a fixed pattern
        repeat (3) run_frame(1, 2, 16'h1234, 3, 0, 16'h0, 0, 0);
        run_frame(1, 2, 16'h1234, 0, 0, 16'h0, 0, 0);

        // Enable drop, then alternating pattern
        repeat (2) run_frame(0, 1, 16'h0, 5, 1, 16'hFFFF, 0, 0);
        repeat (3) run_frame(1, 3, 16'h0, 0, 0, 16'h0, 0, 0);

        // Randomized frames
        for (int i = 0; i < 48; i++) begin
            run_frame(($urandom % 8) != 0, int'($urandom % 4), 16'($urandom),
                      int'($urandom % 8), ($urandom % 4) != 0, 16'($urandom), 0, 0);
        end

        repeat (8) @(posedge clk);
        #1;
        mon_active = 1'b0;
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
